// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch port A (read-only) and data port B (read/write), B-priority.
// Optional starvation guard for port A is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [15:0] address_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 2;
  localparam int unsigned CW = 4;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_A,
    S_BUSY_B,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pmem_read;
  logic          r_pmem_write;
  logic [MW-1:0] r_pmem_wmask;
  logic [AW-1:0] r_pmem_address;
  logic [DW-1:0] r_pmem_wdata;
  logic          w_pmem_read_nxt;
  logic          w_pmem_write_nxt;
  logic [MW-1:0] w_pmem_wmask_nxt;
  logic [AW-1:0] w_pmem_address_nxt;
  logic [DW-1:0] w_pmem_wdata_nxt;
  logic          w_req_a;
  logic          w_req_b;
  logic          w_force_a;
  logic          w_grant_a;
  logic          w_grant_b;

  assign w_req_a   = read_a;
  assign w_req_b   = read_b | write_b;
  assign w_grant_b = (r_state == S_IDLE) && w_req_b && !w_force_a;
  assign w_grant_a = (r_state == S_IDLE) && !w_grant_b && w_req_a;

`ifdef ARB_STARVE_GUARD_EN
  logic [CW-1:0] r_starve_cnt;

  assign w_force_a = w_req_a && (r_starve_cnt == CW'(STARVE_LIMIT));

  // Counts B grants that overtook a waiting A; never exceeds STARVE_LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_b && w_req_a) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end else if (w_grant_a || w_grant_b) begin
      r_starve_cnt <= '0;
    end
  end
`else
  assign w_force_a = 1'b0;
`endif

  // State and memory-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_wmask   <= '0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pmem_read    <= w_pmem_read_nxt;
      r_pmem_write   <= w_pmem_write_nxt;
      r_pmem_wmask   <= w_pmem_wmask_nxt;
      r_pmem_address <= w_pmem_address_nxt;
      r_pmem_wdata   <= w_pmem_wdata_nxt;
    end
  end

  // Next state and next memory command; memory fields hold unless granted or completing.
  always_comb begin
    w_state_nxt        = r_state;
    w_pmem_read_nxt    = r_pmem_read;
    w_pmem_write_nxt   = r_pmem_write;
    w_pmem_wmask_nxt   = r_pmem_wmask;
    w_pmem_address_nxt = r_pmem_address;
    w_pmem_wdata_nxt   = r_pmem_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_b) begin
          // A simultaneous read+write on B is resolved as a write.
          w_state_nxt        = S_BUSY_B;
          w_pmem_read_nxt    = !write_b;
          w_pmem_write_nxt   = write_b;
          w_pmem_wmask_nxt   = wmask_b;
          w_pmem_address_nxt = address_b;
          w_pmem_wdata_nxt   = wdata_b;
        end else if (w_grant_a) begin
          w_state_nxt        = S_BUSY_A;
          w_pmem_read_nxt    = 1'b1;
          w_pmem_write_nxt   = 1'b0;
          w_pmem_wmask_nxt   = '0;
          w_pmem_address_nxt = address_a;
          w_pmem_wdata_nxt   = '0;
        end
      end
      S_BUSY_A, S_BUSY_B: begin
        if (pmem_resp) begin
          w_state_nxt      = S_DONE;
          w_pmem_read_nxt  = 1'b0;
          w_pmem_write_nxt = 1'b0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign resp_a  = (r_state == S_BUSY_A) && pmem_resp;
  assign resp_b  = (r_state == S_BUSY_B) && pmem_resp;
  assign rdata_a = resp_a ? pmem_rdata : '0;
  assign rdata_b = resp_b ? pmem_rdata : '0;

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_wmask   = r_pmem_wmask;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected grants/responses,
// a monitor pops and compares whenever the DUT issues a grant or a response.
module tb_mem_port_arbiter;

  localparam int unsigned LIM = 2;

  logic        clk;
  logic        rst_n;
  logic        read_a;
  logic [15:0] address_a;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
    .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  mask;
    logic [15:0] addr;
    logic [15:0] wdata;
  } grant_t;

  typedef struct packed {
    logic        port_b;
    logic [15:0] rdata;
  } resp_t;

  grant_t exp_g[$];
  resp_t  exp_r[$];
  grant_t cur_g;
  resp_t  cur_r;
  int     n_cmp;
  int     n_err;
  int     n_grants;
  int     mem_lat;
  int     mcnt;
  logic   hold_a;
  logic   b_cont;
  logic   prev_strobe;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [15:0] addr);
    if (addr == 16'h0040) return 16'hBEEF;
    return addr ^ 16'h5A5A;
  endfunction

  // Memory model: responds for one cycle after mem_lat cycles of an active strobe.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    mcnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      if (!rst_n) begin
        mcnt = 0;
      end else if (pmem_read || pmem_write) begin
        mcnt++;
        if (mcnt == mem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_read ? mem_val(pmem_address) : 16'h0000;
          mcnt       = 0;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // Requesters drop their level after the response unless told to hold it.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_a && !hold_a) read_a = 1'b0;
      if (resp_b && !b_cont) begin
        read_b  = 1'b0;
        write_b = 1'b0;
      end
    end
  end

  // Monitor: pops the grant scoreboard on each new strobe, the response scoreboard on each resp.
  initial begin
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if ((pmem_read || pmem_write) && !prev_strobe) begin
        n_grants++;
        if (exp_g.size() == 0) begin
          chk("unexpected_grant", {4'h0, pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata}, 40'h0);
        end else begin
          cur_g = exp_g.pop_front();
          chk("grant", {4'h0, pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata}, {4'h0, cur_g});
        end
      end else if (pmem_read || pmem_write) begin
        chk("hold", {4'h0, pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata}, {4'h0, cur_g});
      end
      chk("resp_excl", 40'(resp_a & resp_b), 40'h0);
      if (resp_a || resp_b) begin
        if (exp_r.size() == 0) begin
          chk("unexpected_resp", {22'h0, resp_a, resp_b, resp_b ? rdata_b : rdata_a}, 40'h0);
        end else begin
          cur_r = exp_r.pop_front();
          chk("resp", {23'h0, resp_b, resp_b ? rdata_b : rdata_a}, {23'h0, cur_r});
        end
      end
      if (!resp_a) chk("rdata_a_zero", 40'(rdata_a), 40'h0);
      if (!resp_b) chk("rdata_b_zero", 40'(rdata_b), 40'h0);
      prev_strobe = pmem_read || pmem_write;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [15:0] addr, input logic [15:0] rdata);
    exp_g.push_back('{rd: 1'b1, wr: 1'b0, mask: 2'b00, addr: addr, wdata: 16'h0000});
    exp_r.push_back('{port_b: 1'b0, rdata: rdata});
  endtask

  task automatic push_b_rd(input logic [15:0] addr, input logic [15:0] rdata);
    exp_g.push_back('{rd: 1'b1, wr: 1'b0, mask: wmask_b, addr: addr, wdata: wdata_b});
    exp_r.push_back('{port_b: 1'b1, rdata: rdata});
  endtask

  task automatic push_b_wr(input logic [1:0] mask, input logic [15:0] addr, input logic [15:0] wdata);
    exp_g.push_back('{rd: 1'b0, wr: 1'b1, mask: mask, addr: addr, wdata: wdata});
    exp_r.push_back('{port_b: 1'b1, rdata: 16'h0000});
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while ((read_a || read_b || write_b) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("quiet_timeout", 40'(k), 40'h0);
    cyc(3);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_cmp = 0; n_err = 0; n_grants = 0; mem_lat = 3;
    hold_a = 1'b0; b_cont = 1'b0;
    rst_n = 1'b0;
    read_a = 1'b0; address_a = '0;
    read_b = 1'b0; write_b = 1'b0; wmask_b = '0; address_b = '0; wdata_b = '0;
    cyc(2);
    chk("rst_pmem", {4'h0, pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata}, 40'h0);
    chk("rst_resp", {38'h0, resp_a, resp_b}, 40'h0);
    rst_n = 1'b1;
    cyc(2);

    // Single A read with exact cycle checks.
    push_a(16'h0040, 16'hBEEF);
    read_a = 1'b1; address_a = 16'h0040;
    cyc(1);
    chk("a_c1", {23'h0, pmem_read, pmem_address}, {23'h0, 1'b1, 16'h0040});
    chk("a_c1_resp", 40'(resp_a), 40'h0);
    cyc(1);
    chk("a_c2", {23'h0, pmem_read, pmem_address}, {23'h0, 1'b1, 16'h0040});
    cyc(1);
    chk("a_c3_resp", {23'h0, resp_a, rdata_a}, {23'h0, 1'b1, 16'hBEEF});
    cyc(1);
    chk("a_c4_done", {38'h0, pmem_read, resp_a}, 40'h0);
    wait_quiet();

    // B write.
    push_b_wr(2'b10, 16'h0100, 16'h12AB);
    write_b = 1'b1; wmask_b = 2'b10; address_b = 16'h0100; wdata_b = 16'h12AB;
    wait_quiet();

    // Illegal read+write on B resolves to a write.
    push_b_wr(2'b01, 16'h0180, 16'h5555);
    read_b = 1'b1; write_b = 1'b1; wmask_b = 2'b01; address_b = 16'h0180; wdata_b = 16'h5555;
    wait_quiet();

    // Simultaneous A and B: B first.
    wmask_b = 2'b00; wdata_b = 16'h0000;
    push_b_rd(16'h0020, 16'h5A7A);
    push_a(16'h0010, 16'h5A4A);
    read_b = 1'b1; address_b = 16'h0020;
    read_a = 1'b1; address_a = 16'h0010;
    wait_quiet();

    // Starvation: B requests continuously while A waits.
`ifdef ARB_STARVE_GUARD_EN
    push_b_rd(16'h0200, 16'h585A);
    push_b_rd(16'h0200, 16'h585A);
    push_a(16'h0300, 16'h595A);
    push_b_rd(16'h0200, 16'h585A);
`else
    push_b_rd(16'h0200, 16'h585A);
    push_b_rd(16'h0200, 16'h585A);
    push_b_rd(16'h0200, 16'h585A);
    push_b_rd(16'h0200, 16'h585A);
    push_a(16'h0300, 16'h595A);
`endif
    k = n_grants;
    b_cont = 1'b1;
    read_b = 1'b1; address_b = 16'h0200;
    read_a = 1'b1; address_a = 16'h0300;
    while (n_grants < k + 4 && n_grants < k + 100) @(negedge clk);
    b_cont = 1'b0;
    wait_quiet();

    // Reset in the middle of a B read.
    mem_lat = 6;
    exp_g.push_back('{rd: 1'b1, wr: 1'b0, mask: 2'b00, addr: 16'h0300, wdata: 16'h0000});
    read_b = 1'b1; address_b = 16'h0300;
    cyc(1);
    chk("rstb_busy", {23'h0, pmem_read, pmem_address}, {23'h0, 1'b1, 16'h0300});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstb_pmem", {4'h0, pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata}, 40'h0);
    chk("rstb_resp", {38'h0, resp_a, resp_b}, 40'h0);
    read_b = 1'b0;
    cyc(1);
    #2;
    rst_n = 1'b1;
    cyc(1);
    mem_lat = 3;
    push_a(16'h0040, 16'hBEEF);
    read_a = 1'b1; address_a = 16'h0040;
    wait_quiet();

    // Stale level held through DONE must not be re-served.
    hold_a = 1'b1;
    push_a(16'h0060, 16'h5A3A);
    read_a = 1'b1; address_a = 16'h0060;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_a && k < 50);
    if (k >= 50) chk("stale_timeout", 40'(k), 40'h0);
    cyc(1);
    chk("stale_done", 40'(pmem_read), 40'h0);
    read_a = 1'b0;
    hold_a = 1'b0;
    cyc(3);
    chk("stale_idle", 40'(pmem_read), 40'h0);

    cyc(5);
    chk("grants_left", 40'(exp_g.size()), 40'h0);
    chk("resps_left", 40'(exp_r.size()), 40'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one physical memory port between the pipeline's instruction-fetch port (A, read-only) and data port (B, read/write). It sits between the CPU datapath's port A/port B handshakes and a single memory, serializing accesses. It latches the winning request, drives the memory until `pmem_resp`, and routes the response back to the winner. Fixed priority favours B so the MEM stage drains; an optional starvation guard bounds A's wait.

## Interface
- `STARVE_LIMIT`, 4: consecutive B grants while A is pending before A is forced (guard build only); range 1–15.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `read_a` in 1: port A read request, level, held until `resp_a`.
- `address_a` in 16: port A address.
- `resp_a` out 1: port A transaction complete.
- `rdata_a` out 16: port A read data, valid with `resp_a`.
- `read_b` in 1: port B read request, level, held until `resp_b`.
- `write_b` in 1: port B write request, level, held until `resp_b`.
- `wmask_b` in 2: port B byte mask.
- `address_b` in 16: port B address.
- `wdata_b` in 16: port B write data.
- `resp_b` out 1: port B transaction complete.
- `rdata_b` out 16: port B read data, valid with `resp_b`.
- `pmem_read` out 1: memory read strobe, registered.
- `pmem_write` out 1: memory write strobe, registered.
- `pmem_wmask` out 2: memory byte mask, registered.
- `pmem_address` out 16: memory address, registered.
- `pmem_wdata` out 16: memory write data, registered.
- `pmem_resp` in 1: memory completion, one cycle.
- `pmem_rdata` in 16: memory read data, valid with `pmem_resp`.

## Operation
- States: IDLE, BUSY_A, BUSY_B, DONE.
- IDLE: `req_a = read_a`; `req_b = read_b | write_b`.
  - B wins if `req_b` and not forced-A; otherwise A wins if `req_a`.
  - On a grant, at the clock edge: latch address/mask/data into the `pmem_*` registers, assert the strobe, enter BUSY_x.
- Both `read_b` and `write_b` high is illegal. The arbiter issues a write, with `pmem_read` = 0.
- Port A grants always carry `pmem_wmask` = 2'b00, `pmem_write` = 0.
- BUSY_x: hold all `pmem_*` registers stable; ignore request inputs.
  - On `pmem_resp`: `resp_x` = 1 combinationally in the same cycle; `rdata_x` = `pmem_rdata`.
  - At the edge: clear the strobes, enter DONE.
- `rdata_a`/`rdata_b` are driven from `pmem_rdata` only while their resp is high, else 0.
- `resp` never asserts for the non-granted port.
- DONE: one dead cycle with no grants, so a requester that has not yet dropped its level request is not re-served. Then IDLE.
- `pmem_resp` in IDLE or DONE is ignored.
- Reset (any time, including mid-BUSY):
  - state = IDLE, all `pmem_*` = 0, starve count = 0.
  - `resp_a` = `resp_b` = 0; the abandoned transaction gets no response.

## Timing
- Request visible in cycle N (IDLE) → `pmem_*` driven in cycle N+1.
- `pmem_resp` in cycle M ≥ N+1 → `resp_x` in cycle M → DONE in M+1 → IDLE in M+2.
- Minimum occupancy is 3 cycles per transaction; next grant no earlier than cycle M+2.
- A request arriving while BUSY/DONE waits; grant evaluation happens only in IDLE.

## Configuration
- Macro `ARB_STARVE_GUARD_EN`.
- Defined:
  - 4-bit `starve_cnt` increments on each B grant made while `req_a` is high.
  - It resets to 0 on any A grant, or on a B grant with `req_a` low.
  - When `starve_cnt == STARVE_LIMIT` and `req_a`, forced-A is set: A wins the next IDLE grant even if `req_b` is high.
- Undefined: no counter; strict priority B > A, and A may starve indefinitely.

## Test plan
- Single A read: `read_a` = 1, `address_a` = 16'h0040 at cycle 0, memory responds in cycle 3 with 16'hBEEF. Expect `pmem_read` = 1 and `pmem_address` = 16'h0040 in cycles 1–3, `resp_a` = 1 and `rdata_a` = 16'hBEEF in cycle 3, DONE in 4, IDLE in 5.
- B write: `write_b`, `wmask_b` = 2'b10, `address_b` = 16'h0100, `wdata_b` = 16'h12AB. Expect `pmem_write` = 1 with those values latched, `pmem_read` = 0, `resp_b` only on `pmem_resp`, `resp_a` stays 0.
- Simultaneous A and B requests in IDLE: B granted first; A granted in the IDLE cycle after B's DONE; each `resp` is exactly one cycle.
- Starvation with guard, `STARVE_LIMIT` = 2, B requesting continuously, A pending: grants B, B, A, B. Without the macro: B on every grant, `resp_a` never asserts.
- Reset mid-BUSY_B: deassert `rst_n` for 1 cycle while `pmem_read` = 1. Expect all `pmem_*` = 0 immediately, no `resp_b`; a fresh A request after release is granted normally.
- Stale level after completion: keep `read_a` high through DONE. Expect no duplicate grant in DONE; a new grant starts only in IDLE.
